// File: rtl/pat_field_buffer.sv
// Pattern buffer bank: bit-addressed field read/write for the processor plus a
// byte-stream load/unload port that fills and drains whole buffers.
module pat_field_buffer #(
    parameter int NUM_BUFS = 8,
    parameter int BUFP_W   = 3,
    parameter int BUF_BITS = 32,
    parameter int FIELDP_W = 5,
    parameter int FIELD_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BUFP_W-1:0]   bufp,
    input  logic [FIELDP_W-1:0] fieldp,
    input  logic [FIELDP_W-1:0] fieldwp,
    input  logic                write_en,
    input  logic [FIELD_W-1:0]  field_out,
    output logic [FIELD_W-1:0]  field_in,
    input  logic                ld_start,
    input  logic [BUFP_W-1:0]   ld_buf,
    input  logic                ld_valid,
    input  logic [FIELD_W-1:0]  ld_data,
    output logic                ld_ready,
    input  logic                ul_start,
    input  logic [BUFP_W-1:0]   ul_buf,
    output logic                ul_valid,
    output logic [FIELD_W-1:0]  ul_data,
    input  logic                ul_ready,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W  = $clog2(BUF_BITS / FIELD_W);
    localparam int LOG_FW = $clog2(FIELD_W);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BUF_BITS / FIELD_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UNLOAD = 2'd2
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [BUF_BITS-1:0]   bufs_r [NUM_BUFS];
    logic [BUFP_W-1:0]     tgt_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_inc_s;
    logic [FIELD_W-1:0]    field_in_r, field_rd_s;
    logic [BUF_BITS-1:0]   rd_sel_s;
    logic                  ul_valid_r, busy_r, done_r;
    logic [FIELD_W-1:0]    ul_data_r;
    logic                  ld_ready_s, ld_xfer_s, ul_xfer_s, last_s;
    logic                  ld_go_s, ul_go_s;

    // Bit offset of stream byte k within a buffer.
    function automatic logic [FIELDP_W-1:0] byte_off(input logic [CNT_W-1:0] k);
        return {k, {LOG_FW{1'b0}}};
    endfunction

    assign cnt_inc_s = cnt_r + CNT_W'(1);
    assign last_s    = (cnt_r == LAST_BYTE);
    assign ld_xfer_s = ld_valid & ld_ready_s;
    assign ul_xfer_s = (state_r == UNLOAD) & ul_valid_r & ul_ready;

    // A processor write to the load target stalls the stream for that cycle.
    always_comb begin
        ld_ready_s = 1'b0;
        if (state_r == LOAD) begin
            ld_ready_s = ~write_en | (bufp != tgt_r);
        end else begin
            ld_ready_s = 1'b0;
        end
    end

    // Wrapping bit-field read mux.
    always_comb begin
        rd_sel_s   = bufs_r[bufp];
        field_rd_s = '0;
        for (int i = 0; i < FIELD_W; i++) begin
            field_rd_s[i] = rd_sel_s[fieldp + FIELDP_W'(i)];
        end
    end

    // Next-state logic; load wins over unload when both start together.
    always_comb begin
        state_nxt_s = state_r;
        ld_go_s     = 1'b0;
        ul_go_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (ld_start) begin
                    ld_go_s     = 1'b1;
                    state_nxt_s = LOAD;
                end else if (ul_start) begin
                    ul_go_s     = 1'b1;
                    state_nxt_s = UNLOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (ld_xfer_s && last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            UNLOAD: begin
                if (ul_xfer_s && last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = UNLOAD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Buffer storage; the field write is applied after the load byte so it wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BUFS; b++) begin
                bufs_r[b] <= '0;
            end
        end else begin
            if (ld_xfer_s) begin
                bufs_r[tgt_r][byte_off(cnt_r) +: FIELD_W] <= ld_data;
            end
            if (write_en) begin
                for (int i = 0; i < FIELD_W; i++) begin
                    bufs_r[bufp][fieldwp + FIELDP_W'(i)] <= field_out[i];
                end
            end
        end
    end

    // Transfer target, byte counter and unload output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_r      <= '0;
            cnt_r      <= '0;
            ul_valid_r <= 1'b0;
            ul_data_r  <= '0;
        end else if (ld_go_s) begin
            tgt_r <= ld_buf;
            cnt_r <= '0;
        end else if (ul_go_s) begin
            tgt_r      <= ul_buf;
            cnt_r      <= '0;
            ul_valid_r <= 1'b1;
            ul_data_r  <= bufs_r[ul_buf][byte_off(CNT_W'(0)) +: FIELD_W];
        end else if (ld_xfer_s) begin
            cnt_r <= cnt_inc_s;
        end else if (ul_xfer_s) begin
            if (last_s) begin
                ul_valid_r <= 1'b0;
            end else begin
                cnt_r     <= cnt_inc_s;
                ul_data_r <= bufs_r[tgt_r][byte_off(cnt_inc_s) +: FIELD_W];
            end
        end
    end

    // Registered field read, busy flag and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_in_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            field_in_r <= field_rd_s;
            busy_r     <= (state_nxt_s != IDLE);
            done_r     <= (ld_xfer_s | ul_xfer_s) & last_s;
        end
    end

    assign field_in = field_in_r;
    assign ld_ready = ld_ready_s;
    assign ul_valid = ul_valid_r;
    assign ul_data  = ul_data_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_pat_field_buffer.sv
// Directed bench for pat_field_buffer: table of field read/write vectors plus
// hand-written load, conflict, unload-backpressure and reset-abort sequences.
module tb_pat_field_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] bufp;
    logic [4:0] fieldp, fieldwp;
    logic       write_en;
    logic [7:0] field_out, field_in;
    logic       ld_start, ld_valid, ld_ready;
    logic [2:0] ld_buf, ul_buf;
    logic [7:0] ld_data, ul_data;
    logic       ul_start, ul_valid, ul_ready, busy, done;

    int checks = 0;
    int failures = 0;

    pat_field_buffer dut (
        .clk(clk), .rst_n(rst_n), .bufp(bufp), .fieldp(fieldp), .fieldwp(fieldwp),
        .write_en(write_en), .field_out(field_out), .field_in(field_in),
        .ld_start(ld_start), .ld_buf(ld_buf), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ul_start(ul_start), .ul_buf(ul_buf), .ul_valid(ul_valid),
        .ul_data(ul_data), .ul_ready(ul_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] bufp;
        logic [4:0] fieldp;
        logic       wen;
        logic [4:0] fieldwp;
        logic [7:0] fout;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] b, input logic [4:0] fp, input logic [7:0] exp,
                      input string name);
        bufp = b; fieldp = fp; write_en = 1'b0;
        tick();
        check(name, {24'h0, field_in}, {24'h0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ld_bytes [4];
        logic [7:0] ul_exp [4];
        vecs[0]  = '{3'd2, 5'd8,  1'b0, 5'd0,  8'h00, 8'h22};
        vecs[1]  = '{3'd2, 5'd4,  1'b0, 5'd0,  8'h00, 8'h21};
        vecs[2]  = '{3'd2, 5'd28, 1'b0, 5'd0,  8'h00, 8'h14};
        vecs[3]  = '{3'd2, 5'd0,  1'b0, 5'd0,  8'h00, 8'h11};
        vecs[4]  = '{3'd2, 5'd24, 1'b0, 5'd0,  8'h00, 8'h44};
        vecs[5]  = '{3'd3, 5'd0,  1'b0, 5'd0,  8'h00, 8'h00};
        vecs[6]  = '{3'd2, 5'd28, 1'b1, 5'd28, 8'hAB, 8'h14};
        vecs[7]  = '{3'd2, 5'd28, 1'b0, 5'd0,  8'h00, 8'hAB};
        vecs[8]  = '{3'd2, 5'd0,  1'b0, 5'd0,  8'h00, 8'h1A};
        vecs[9]  = '{3'd2, 5'd24, 1'b0, 5'd0,  8'h00, 8'hB4};
        vecs[10] = '{3'd7, 5'd4,  1'b1, 5'd4,  8'h5A, 8'h00};
        vecs[11] = '{3'd7, 5'd4,  1'b0, 5'd0,  8'h00, 8'h5A};
        vecs[12] = '{3'd7, 5'd0,  1'b0, 5'd0,  8'h00, 8'hA0};
        vecs[13] = '{3'd7, 5'd8,  1'b0, 5'd0,  8'h00, 8'h05};

        rst_n = 1'b0; bufp = '0; fieldp = '0; fieldwp = '0; write_en = 1'b0;
        field_out = '0; ld_start = 1'b0; ld_buf = '0; ld_valid = 1'b0; ld_data = '0;
        ul_start = 1'b0; ul_buf = '0; ul_ready = 1'b0;
        tick();
        tick();
        check("rst_field_in", {24'h0, field_in}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        check("rst_ul_valid", {31'h0, ul_valid}, 32'h0);
        check("rst_ul_data", {24'h0, ul_data}, 32'h0);
        rst_n = 1'b1;
        rd(3'd0, 5'd0, 8'h00, "read_after_reset");

        // Load buffer 2 with 0x44332211.
        ld_bytes[0] = 8'h11; ld_bytes[1] = 8'h22; ld_bytes[2] = 8'h33; ld_bytes[3] = 8'h44;
        ld_start = 1'b1; ld_buf = 3'd2;
        tick();
        ld_start = 1'b0;
        check("load_busy", {31'h0, busy}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            ld_valid = 1'b1; ld_data = ld_bytes[k];
            #1;
            check("load_ready", {31'h0, ld_ready}, 32'h1);
            check("load_no_early_done", {31'h0, done}, 32'h0);
            tick();
        end
        ld_valid = 1'b0;
        check("load_done_pulse", {31'h0, done}, 32'h1);
        check("load_busy_clear", {31'h0, busy}, 32'h0);
        tick();
        check("load_done_single", {31'h0, done}, 32'h0);

        // Field read/write table, including wrap and same-cycle read-old-data.
        for (int v = 0; v < 14; v++) begin
            bufp = vecs[v].bufp; fieldp = vecs[v].fieldp; write_en = vecs[v].wen;
            fieldwp = vecs[v].fieldwp; field_out = vecs[v].fout;
            tick();
            check($sformatf("vec%0d_field_in", v), {24'h0, field_in}, {24'h0, vecs[v].exp});
        end
        write_en = 1'b0;

        // Load buffer 5 while the processor writes into it (stall) and into buffer 4 (no stall).
        ld_start = 1'b1; ld_buf = 3'd5;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'hC1;
        tick();
        ld_data = 8'hC2;
        for (int c = 0; c < 2; c++) begin
            write_en = 1'b1; bufp = 3'd5; fieldwp = 5'd24; field_out = 8'h77;
            #1;
            check("conflict_ld_ready_low", {31'h0, ld_ready}, 32'h0);
            tick();
        end
        bufp = 3'd4; fieldwp = 5'd0; field_out = 8'h3C;
        #1;
        check("other_buf_ld_ready_high", {31'h0, ld_ready}, 32'h1);
        tick();
        write_en = 1'b0;
        ld_data = 8'hC3;
        tick();
        ld_data = 8'hC4;
        check("conflict_not_done_early", {31'h0, done}, 32'h0);
        tick();
        ld_valid = 1'b0;
        check("conflict_done", {31'h0, done}, 32'h1);
        rd(3'd5, 5'd0,  8'hC1, "buf5_byte0");
        rd(3'd5, 5'd8,  8'hC2, "buf5_byte1");
        rd(3'd5, 5'd16, 8'hC3, "buf5_byte2");
        rd(3'd5, 5'd24, 8'hC4, "buf5_byte3");
        rd(3'd4, 5'd0,  8'h3C, "buf4_byte0");

        // Unload buffer 2 (0xB433221A) with initial backpressure.
        ul_exp[0] = 8'h1A; ul_exp[1] = 8'h22; ul_exp[2] = 8'h33; ul_exp[3] = 8'hB4;
        ul_start = 1'b1; ul_buf = 3'd2; ul_ready = 1'b0;
        tick();
        ul_start = 1'b0;
        check("unload_busy", {31'h0, busy}, 32'h1);
        for (int c = 0; c < 3; c++) begin
            check("bp_ul_valid", {31'h0, ul_valid}, 32'h1);
            check("bp_ul_data", {24'h0, ul_data}, 32'h1A);
            tick();
        end
        ul_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("stream_ul_valid", {31'h0, ul_valid}, 32'h1);
            check($sformatf("stream_byte%0d", k), {24'h0, ul_data}, {24'h0, ul_exp[k]});
            check("stream_no_early_done", {31'h0, done}, 32'h0);
            tick();
        end
        check("unload_valid_clear", {31'h0, ul_valid}, 32'h0);
        check("unload_done", {31'h0, done}, 32'h1);
        check("unload_busy_clear", {31'h0, busy}, 32'h0);
        tick();
        check("unload_done_single", {31'h0, done}, 32'h0);

        // Reset in the middle of an unload after two bytes.
        ul_start = 1'b1; ul_buf = 3'd2; ul_ready = 1'b1;
        tick();
        ul_start = 1'b0;
        tick();
        tick();
        check("mid_ul_data_byte2", {24'h0, ul_data}, 32'h33);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_ul_valid", {31'h0, ul_valid}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        ul_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_no_done_after", {31'h0, done}, 32'h0);
        check("abort_busy_after", {31'h0, busy}, 32'h0);
        rd(3'd2, 5'd0, 8'h00, "buf2_cleared");
        rd(3'd5, 5'd8, 8'h00, "buf5_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
